// File: rtl/rr_mux.sv
// rr_mux: N-to-1 registered mux with internal round-robin grant; RR_MUX_FIXED_PRIO_EN selects fixed lowest-index priority.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle when out_ready stays high.
// Backpressure: single output register, no skid; in_ready is all zeros while the held word is stalled.
module rr_mux #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel
);

  logic [W-1:0]  ch [N];
  logic [SW-1:0] ptr;
  logic [SW-1:0] gnt;
  logic          gnt_vld;
  logic          load_en;
  int            pos;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch[i] = in_data[i*W +: W];
  end

  // Search from ptr upward with wrap; first valid channel wins.
  always_comb begin
    load_en  = !out_valid || out_ready;
    gnt_vld  = 1'b0;
    gnt      = '0;
    in_ready = '0;
    pos      = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!gnt_vld && in_valid[pos[SW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = pos[SW-1:0];
      end
    end
    if (load_en && gnt_vld && !rst) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= ch[gnt];
        out_sel  <= gnt;
      end
    end
  end

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (load_en && gnt_vld) begin
      ptr <= (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux (N=4, W=8) with immediate-assertion checks.
module tb_rr_mux;

  localparam int N = 4;
  localparam int W = 8;
`ifdef RR_MUX_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;

  int checks;
  int failures;

  rr_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_sel;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state before any clock edge
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_out_sel",   32'(out_sel),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    tick();
    rst = 1'b0;

    // Single channel 2
    in_valid  = 4'b0100;
    in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
    out_ready = 1'b1;
    #1;
    check("single_in_ready", 32'(in_ready), 32'b0100);
    tick();
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_out_data",  32'(out_data),  32'hA5);
    check("single_out_sel",   32'(out_sel),   32'd2);

    // Idle cycle: output drains, data/sel hold
    in_valid = 4'b0000;
    tick();
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_out_data",  32'(out_data),  32'hA5);
    check("idle_out_sel",   32'(out_sel),   32'd2);

    // Wrap/skip: ptr=3, channels 0 and 1 valid
    in_valid = 4'b0011;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    #1;
    check("wrap_in_ready0", 32'(in_ready), 32'b0001);
    tick();
    check("wrap_sel0",  32'(out_sel),  32'd0);
    check("wrap_data0", 32'(out_data), 32'h10);
    check("wrap_in_ready1", 32'(in_ready), FIXED ? 32'b0001 : 32'b0010);
    tick();
    check("wrap_sel1",  32'(out_sel),  FIXED ? 32'd0 : 32'd1);
    check("wrap_data1", 32'(out_data), FIXED ? 32'h10 : 32'h11);

    // Mid-stream asynchronous reset with a held word and all inputs valid
    in_valid = 4'b1111;
    rst      = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  32'(out_data),  32'h00);
    check("midrst_out_sel",   32'(out_sel),   32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'b0001);

    // Round robin, all valid, out_ready held high: no bubbles
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_sel = FIXED ? 0 : (k % 4);
      check($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("rr_sel_%0d", k),   32'(out_sel),   32'(exp_sel));
      check($sformatf("rr_data_%0d", k),  32'(out_data),  32'(8'h10 + exp_sel));
    end

    // Backpressure for 3 cycles
    out_ready = 1'b0;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp_valid_%0d", k),    32'(out_valid), 32'd1);
      check($sformatf("bp_sel_%0d", k),      32'(out_sel),   FIXED ? 32'd0 : 32'd3);
      check($sformatf("bp_data_%0d", k),     32'(out_data),  FIXED ? 32'h10 : 32'h13);
      check($sformatf("bp_in_ready_%0d", k), 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("resume_in_ready", 32'(in_ready), 32'b0001);
    tick();
    check("resume_sel",  32'(out_sel),  32'd0);
    check("resume_data", 32'(out_data), 32'h10);

    // Drain
    in_valid = 4'b0000;
    tick();
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_in_ready",  32'(in_ready),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
